// File: rtl/sobel_pad_stream.sv
// Border-padding scanner for the Sobel datapath: walks the (optionally padded)
// output raster, inserting PAD_VALUE on border positions and forwarding interior pixels.
module sobel_pad_stream #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       IMG_W     = 640,
  parameter int unsigned       IMG_H     = 480,
  parameter int unsigned       PAD       = 1,
  parameter int unsigned       CNT_W     = 10,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pad_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_row,
  output logic [CNT_W-1:0]  out_col,
  output logic              out_is_pad,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned CW1 = CNT_W + 1;

  localparam logic [CNT_W-1:0] PAD_W_M1 = CNT_W'(IMG_W + 2 * PAD - 1);
  localparam logic [CNT_W-1:0] PAD_H_M1 = CNT_W'(IMG_H + 2 * PAD - 1);
  localparam logic [CNT_W-1:0] RAW_W_M1 = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] RAW_H_M1 = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W:0]   PAD_X    = CW1'(PAD);
  localparam logic [CNT_W:0]   IMG_W_X  = CW1'(IMG_W);
  localparam logic [CNT_W:0]   IMG_H_X  = CW1'(IMG_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic             mode_q;
  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] col_q;

  logic [CNT_W-1:0] ow_m1;
  logic [CNT_W-1:0] oh_m1;
  logic [CNT_W:0]   off;
  logic [CNT_W:0]   row_rel;
  logic [CNT_W:0]   col_rel;
  logic             pos_pad;
  logic             pos_last;
  logic             slot_free;
  logic             load;
  logic             clear_scan;

  // Position classification. Offsetting by PAD with one guard bit makes
  // positions above/left of the interior wrap to huge values, so a single
  // upper-bound compare per axis detects all four borders.
  always_comb begin
    ow_m1     = mode_q ? PAD_W_M1 : RAW_W_M1;
    oh_m1     = mode_q ? PAD_H_M1 : RAW_H_M1;
    off       = mode_q ? PAD_X : '0;
    row_rel   = {1'b0, row_q} - off;
    col_rel   = {1'b0, col_q} - off;
    pos_pad   = (row_rel >= IMG_H_X) || (col_rel >= IMG_W_X);
    pos_last  = (row_q == oh_m1) && (col_q == ow_m1);
    slot_free = !out_valid || out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, load strobe and input handshake.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    in_ready   = 1'b0;
    clear_scan = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          clear_scan = 1'b1;
        end
      end
      RUN: begin
        in_ready = !pos_pad && slot_free;
        load     = slot_free && (pos_pad || in_valid);
        if (load && pos_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Scan counters always point at the next position to load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= 1'b0;
      row_q  <= '0;
      col_q  <= '0;
    end else if (clear_scan) begin
      mode_q <= pad_en;
      row_q  <= '0;
      col_q  <= '0;
    end else if (load) begin
      if (col_q == ow_m1) begin
        col_q <= '0;
        row_q <= row_q + CNT_W'(1);
      end else begin
        col_q <= col_q + CNT_W'(1);
      end
    end
  end

  // Output register; fields only change on a load so they hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      out_is_pad <= 1'b0;
      out_last   <= 1'b0;
    end else if (load) begin
      out_data   <= pos_pad ? PAD_VALUE : in_data;
      out_valid  <= 1'b1;
      out_row    <= row_q;
      out_col    <= col_q;
      out_is_pad <= pos_pad;
      out_last   <= pos_last;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      busy       <= (state_next != IDLE);
      frame_done <= (state == DRAIN) && out_valid && out_ready;
    end
  end

endmodule

// File: tb/tb_sobel_pad_stream.sv
// Scoreboard bench for sobel_pad_stream: two geometries, randomized data,
// stalls and backpressure, checked against a raster-level reference model.
module tb_sobel_pad_stream;

  typedef struct {
    logic [7:0] d;
    int         r;
    int         c;
    bit         pad;
    bit         last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v [2];
  logic       pad_en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;

  logic       iready [2];
  logic [7:0] odata  [2];
  logic       ovalid [2];
  logic [9:0] orow   [2];
  logic [9:0] ocol   [2];
  logic       opad   [2];
  logic       olast  [2];
  logic       busy_o [2];
  logic       fd     [2];

  int         checks   = 0;
  int         failures = 0;
  int         out_cnt  = 0;
  int         sel      = 0;
  exp_t       exp_q[$];
  logic [7:0] px[$];

  always #5 clk = ~clk;

  sobel_pad_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(3), .PAD(1), .CNT_W(10), .PAD_VALUE(8'h00)) u_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .pad_en(pad_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(iready[0]),
    .out_data(odata[0]), .out_valid(ovalid[0]), .out_ready(out_ready),
    .out_row(orow[0]), .out_col(ocol[0]), .out_is_pad(opad[0]), .out_last(olast[0]),
    .busy(busy_o[0]), .frame_done(fd[0])
  );

  sobel_pad_stream #(.DATA_W(8), .IMG_W(2), .IMG_H(2), .PAD(2), .CNT_W(10), .PAD_VALUE(8'hFF)) u_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .pad_en(pad_en),
    .in_data(in_data), .in_valid(in_valid), .in_ready(iready[1]),
    .out_data(odata[1]), .out_valid(ovalid[1]), .out_ready(out_ready),
    .out_row(orow[1]), .out_col(ocol[1]), .out_is_pad(opad[1]), .out_last(olast[1]),
    .busy(busy_o[1]), .frame_done(fd[1])
  );

  // Monitor: handshakes are decided by values stable at the falling edge.
  initial begin : monitor
    bit         stall_prev = 0;
    bit         fd_next = 0;
    bit         exp_fd;
    logic [7:0] p_d;
    logic [9:0] p_r, p_c;
    logic       p_pad, p_last;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
        fd_next    = 0;
      end else begin
        exp_fd  = fd_next;
        fd_next = 0;
        checks++;
        if (fd[sel] !== exp_fd) begin
          failures++;
          $display("FAIL frame_done: got %b want %b", fd[sel], exp_fd);
        end
        if (exp_fd) begin
          checks++;
          if (busy_o[sel] !== 1'b0) begin
            failures++;
            $display("FAIL busy_in_done_cycle: got %b want 0", busy_o[sel]);
          end
        end
        if (stall_prev) begin
          checks++;
          if (ovalid[sel] !== 1'b1 || odata[sel] !== p_d || orow[sel] !== p_r ||
              ocol[sel] !== p_c || opad[sel] !== p_pad || olast[sel] !== p_last) begin
            failures++;
            $display("FAIL stall_stable: got v=%b d=%h r=%0d c=%0d want v=1 d=%h r=%0d c=%0d",
                     ovalid[sel], odata[sel], orow[sel], ocol[sel], p_d, p_r, p_c);
          end
        end
        if (ovalid[sel] === 1'b1 && out_ready === 1'b1) begin
          out_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got d=%h r=%0d c=%0d want none",
                     odata[sel], orow[sel], ocol[sel]);
          end else begin
            e = exp_q.pop_front();
            if (odata[sel] !== e.d || orow[sel] !== 10'(e.r) || ocol[sel] !== 10'(e.c) ||
                opad[sel] !== e.pad || olast[sel] !== e.last) begin
              failures++;
              $display("FAIL pixel%0d: got d=%h r=%0d c=%0d pad=%b last=%b want d=%h r=%0d c=%0d pad=%b last=%b",
                       out_cnt, odata[sel], orow[sel], ocol[sel], opad[sel], olast[sel],
                       e.d, e.r, e.c, e.pad, e.last);
            end
            if (e.last) fd_next = 1;
          end
        end
        stall_prev = (ovalid[sel] === 1'b1) && (out_ready === 1'b0);
        p_d = odata[sel]; p_r = orow[sel]; p_c = ocol[sel];
        p_pad = opad[sel]; p_last = olast[sel];
      end
    end
  end

  task automatic reset_check(input int s, input string name);
    checks++;
    if ({ovalid[s], iready[s], odata[s], orow[s], ocol[s], opad[s], olast[s], busy_o[s], fd[s]} !== '0) begin
      failures++;
      $display("FAIL %s: got v=%b rdy=%b d=%h r=%0d c=%0d pad=%b last=%b busy=%b done=%b want all 0",
               name, ovalid[s], iready[s], odata[s], orow[s], ocol[s], opad[s], olast[s], busy_o[s], fd[s]);
    end
  endtask

  // Runs one frame; entered and left just after a rising edge.
  task automatic run_frame(input int s, input bit mode, input bit stall, input int abort_at,
                           input bit junk, input bit rnd);
    int         w, h, p, pm, ow, oh, n, idx, cyc, k;
    logic [7:0] pv;
    bit         pad, done;
    w  = (s == 0) ? 4 : 2;
    h  = (s == 0) ? 3 : 2;
    p  = (s == 0) ? 1 : 2;
    pv = (s == 0) ? 8'h00 : 8'hFF;
    pm = mode ? p : 0;
    ow = w + 2 * pm;
    oh = h + 2 * pm;
    n  = w * h;
    px.delete();
    for (int i = 0; i < n; i++) px.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1));
    k = 0;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        exp_t e;
        pad = mode && (r < p || r >= p + h || c < p || c >= p + w);
        e.d = pad ? pv : px[k];
        if (!pad) k++;
        e.r = r; e.c = c; e.pad = pad;
        e.last = (r == oh - 1) && (c == ow - 1);
        exp_q.push_back(e);
      end
    end
    out_cnt    = 0;
    start_v[s] = 1'b1;
    pad_en     = mode;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    @(posedge clk); #1;
    start_v[s] = 1'b0;
    pad_en     = ~mode;
    checks++;
    if (busy_o[s] !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start: got %b want 1", busy_o[s]);
    end
    idx  = 0;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 2000) begin
      in_valid   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data    = (idx < n) ? px[idx] : 8'h00;
      out_ready  = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start_v[s] = junk && (cyc == 5);
      if (junk && cyc == 5) pad_en = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && iready[s]) idx++;
      @(posedge clk); #1;
      if (cyc == 0 && mode) begin
        checks++;
        if (ovalid[s] !== 1'b1) begin
          failures++;
          $display("FAIL first_load_latency: got out_valid=%b want 1", ovalid[s]);
        end
      end
      cyc++;
      if (fd[s] === 1'b1) done = 1;
      if (abort_at > 0 && out_cnt >= abort_at) break;
    end
    start_v[s] = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    if (abort_at == 0) begin
      checks++;
      if (!done) begin
        failures++;
        $display("FAIL frame_timeout: got no frame_done after %0d cycles want done", cyc);
      end
      checks++;
      if (idx != n) begin
        failures++;
        $display("FAIL input_count: got %0d want %0d", idx, n);
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL output_count: got %0d missing want 0", exp_q.size());
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    pad_en     = 1'b0;
    in_data    = 8'h00;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_check(0, "reset_a");
    reset_check(1, "reset_b");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_frame(0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run_frame(0, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    run_frame(0, 1'b1, 1'b0, 10, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    reset_check(0, "abort_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run_frame(0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    sel = 1;
    run_frame(1, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    run_frame(1, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_pad_stream.md
# sobel_pad_stream

Streaming border-padding stage for the Sobel edge-detection datapath. It consumes one raw frame of IMG_W×IMG_H pixels over a valid/ready stream and emits a frame of (IMG_W+2·PAD)×(IMG_H+2·PAD) pixels. Border positions are filled with a constant, and each output pixel carries its row/column coordinates and a pad flag. It sits between the pixel source and the 3×3 window/line-buffer stage, and replaces the per-coordinate combinational padding check with a sequential, parametrised scanner.

## Interface
- DATA_W, 8, pixel width
- IMG_W, 640, interior (unpadded) frame width in pixels, ≥1
- IMG_H, 480, interior frame height in pixels, ≥1
- PAD, 1, border thickness in pixels on every side, ≥0
- CNT_W, 10, coordinate width; must hold IMG_W+2·PAD−1 and IMG_H+2·PAD−1
- PAD_VALUE, 0, DATA_W-bit constant driven on pad positions

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle frame start request; honoured only in IDLE
- pad_en  in  1  sampled with start; 1 = padded frame, 0 = pass-through IMG_W×IMG_H frame
- in_data  in  DATA_W  raw pixel, raster order
- in_valid  in  1  in_data valid
- in_ready  out  1  stage accepts in_data this cycle
- out_data  out  DATA_W  output pixel (registered)
- out_valid  out  1  output register holds a pixel
- out_ready  in  1  downstream accepts output
- out_row  out  CNT_W  row of out_data in the output frame
- out_col  out  CNT_W  column of out_data in the output frame
- out_is_pad  out  1  out_data is a pad pixel
- out_last  out  1  out_data is the final pixel of the frame
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse on the handshake of the out_last pixel

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE→RUN on start. This transition clears the row/col scan counters and latches pad_en into mode_q.
- Geometry: OW = IMG_W+2·PAD and OH = IMG_H+2·PAD when mode_q=1; OW = IMG_W and OH = IMG_H when mode_q=0.
- Scan counters (r,c) always address the next position to load. Raster order, c fastest. Wrap c=OW−1 → c=0, r+1.
- A position is pad when mode_q=1 and (r<PAD or r≥PAD+IMG_H or c<PAD or c≥PAD+IMG_W). With mode_q=0 no position is pad.
- slot_free = !out_valid || out_ready.
- in_ready = (state==RUN) && !pad(r,c) && slot_free. in_ready is combinational from out_ready. No other input path exists.
- Load occurs when state==RUN && slot_free && (pad(r,c) || in_valid). On a load:
  - out_data ← PAD_VALUE on pad positions, else in_data.
  - out_row/out_col ← r/c.
  - out_is_pad ← pad(r,c).
  - out_last ← (r==OH−1 && c==OW−1).
  - out_valid ← 1.
  - Counters advance.
- Pad positions never consume input. Interior positions consume exactly one input pixel.
- When the last position is loaded: RUN→DRAIN. No further input is accepted.
- In DRAIN, on out_valid&&out_ready: out_valid←0, frame_done pulses, and state→IDLE.
- In RUN, when out_ready=1 and no load occurs, out_valid←0. Output fields otherwise hold their value.
- start is ignored outside IDLE. pad_en is ignored except when start is sampled.
- Degenerate PAD=0: the behaviour is identical to mode_q=0.

## Timing
- Reset values: out_valid=0, in_ready=0, out_data=0, out_row=0, out_col=0, out_is_pad=0, out_last=0, busy=0, frame_done=0, state=IDLE, mode_q=0.
- rst asserted mid-frame aborts the frame immediately. No frame_done is produced. The partial frame is discarded.
- start high at edge k: busy=1 from k. The earliest first load is edge k+1, so out_valid=1 after k+1.
- Throughput is one output per cycle with out_ready held high and in_valid high on interior positions. Pad runs proceed without input.
- Latency is one register stage: an input accepted at edge n appears on the output after edge n.
- When out_valid=1 and out_ready=0, all out_* fields are stable.
- frame_done asserts for exactly one cycle after the edge completing the out_last handshake. In that same cycle busy=0, and a new start is accepted.
- Output count per frame: OW·OH. Input count per frame: IMG_W·IMG_H.

## Test plan
- Padded frame, back-to-back, with IMG_W=4, IMG_H=3, PAD=1, PAD_VALUE=0, pad_en=1, in_data=1..12, out_ready=1 → expect:
  - 30 outputs;
  - first 7 outputs are pad (0) at (0,0)…(1,0);
  - (1,1)=1 and (3,4)=12;
  - out_last at (4,5);
  - frame_done one cycle after that handshake;
  - exactly 12 in_ready&&in_valid handshakes.
- Pass-through frame with the same parameters and pad_en=0 → expect:
  - 12 outputs, out_is_pad always 0;
  - coordinates (0,0)…(2,3);
  - out_last on pixel 12.
- Backpressure: toggle out_ready 1,0,0,1 repeating and stall in_valid randomly → expect:
  - out_* stable while stalled;
  - no dropped or duplicated pixels;
  - output sequence identical to scenario 1.
- Reset mid-frame: assert rst after the 10th output → expect all outputs at reset values next cycle. A following start produces a complete, correct 30-pixel frame.
- Start while busy: pulse start and toggle pad_en during RUN → expect no effect on the frame. Start in the frame_done cycle → expect a new frame to begin.
- PAD=2, PAD_VALUE=8'hFF with IMG_W=2, IMG_H=2 → expect:
  - 36 outputs;
  - only (2,2),(2,3),(3,2),(3,3) non-pad;
  - all other outputs 8'hFF.
